writeback_arbiter: RTL and testbench

//   Sole driver of the register file write port (rd / wr_en / rd_value).

---
 rtl/writeback_arbiter.sv | 113 +++++++++++
 tb/tb_writeback_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Register file write-port arbiter: merges the in-order pipeline writeback with
// a FIFO-buffered multi-cycle result stream, and exports a pending-destination mask.
module writeback_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8,
    parameter int DATA_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pipe_valid,
    input  logic [4:0]              pipe_rd,
    input  logic [DATA_W-1:0]       pipe_data,
    output logic                    pipe_stall,
    input  logic                    mc_valid,
    output logic                    mc_ready,
    input  logic [4:0]              mc_rd,
    input  logic [DATA_W-1:0]       mc_data,
    output logic [4:0]              rd,
    output logic                    wr_en,
    output logic [DATA_W-1:0]       rd_value,
    output logic [31:0]             pend_mask,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [4:0]        rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     starve_cnt;

    logic fifo_ne;
    logic push;
    logic pop;
    logic pipe_win;
    logic [PW-1:0] off;

    assign fifo_count = cnt;
    assign fifo_ne    = (cnt != '0);
    assign mc_ready   = (cnt < CW'(DEPTH));

    // Destination 0 completes the handshake but is dropped: x0 is never written.
    assign push       = mc_valid & mc_ready & (mc_rd != 5'd0);

    // Stage p0: combinational arbitration
    assign pipe_stall = (starve_cnt == SW'(STARVE_LIM));
    assign pipe_win   = ~pipe_stall & pipe_valid & (pipe_rd != 5'd0);
    assign pop        = fifo_ne & ~pipe_win;

    always_comb begin
        pend_mask = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ({1'b0, off} < cnt)
                pend_mask[rd_mem[i]] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= mc_rd;
            data_mem[wr_ptr] <= mc_data;
        end
    end

    // Stage p1: FIFO bookkeeping and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            starve_cnt <= '0;
            rd         <= '0;
            wr_en      <= 1'b0;
            rd_value   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase

            if (!fifo_ne || pop)
                starve_cnt <= '0;
            else if (pipe_win)
                starve_cnt <= starve_cnt + SW'(1);

            if (pipe_win) begin
                wr_en    <= 1'b1;
                rd       <= pipe_rd;
                rd_value <= pipe_data;
            end else if (pop) begin
                wr_en    <= 1'b1;
                rd       <= rd_mem[rd_ptr];
                rd_value <= data_mem[rd_ptr];
            end else begin
                wr_en    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: vector table plus reset and starvation sequences.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic [4:0]  rd;
    logic        wr_en;
    logic [31:0] rd_value;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;

    int n_vec  = 0;
    int n_fail = 0;

    writeback_arbiter #(.DEPTH(4), .STARVE_LIM(8), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_rd      (mc_rd),
        .mc_data    (mc_data),
        .rd         (rd),
        .wr_en      (wr_en),
        .rd_value   (rd_value),
        .pend_mask  (pend_mask),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic [2:0]  e_cnt;
        logic [31:0] e_pend;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        pipe_valid = pv;
        pipe_rd    = prd;
        pipe_data  = pd;
        mc_valid   = mv;
        mc_rd      = mrd;
        mc_data    = md;
    endtask

    task automatic chk_port(input string tag, input logic e_wr, input logic [4:0] e_rd,
                            input logic [31:0] e_val, input logic [2:0] e_cnt,
                            input logic [31:0] e_pend, input logic e_rdy, input logic e_stall);
        chk({tag, ".wr_en"},      32'(wr_en),      32'(e_wr));
        chk({tag, ".rd"},         32'(rd),         32'(e_rd));
        chk({tag, ".rd_value"},   rd_value,        e_val);
        chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(e_cnt));
        chk({tag, ".pend_mask"},  pend_mask,       e_pend);
        chk({tag, ".mc_ready"},   32'(mc_ready),   32'(e_rdy));
        chk({tag, ".pipe_stall"}, 32'(pipe_stall), 32'(e_stall));
    endtask

    initial begin
        // PIPE only, then x0 write suppressed
        tbl.push_back(vec_t'{1, 5, 32'hDEADBEEF, 0, 0, 0,       1, 5, 32'hDEADBEEF, 0, 32'h0, 1, 0});
        tbl.push_back(vec_t'{1, 0, 32'h11111111, 0, 0, 0,       0, 5, 32'hDEADBEEF, 0, 32'h0, 1, 0});
        // MC into idle port: pending next cycle, written the cycle after
        tbl.push_back(vec_t'{0, 0, 0, 1, 7, 32'h1234,           0, 5, 32'hDEADBEEF, 1, 32'h80, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0,                  1, 7, 32'h1234, 0, 32'h0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0,                  0, 7, 32'h1234, 0, 32'h0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 0, 32'h99,             0, 7, 32'h1234, 0, 32'h0, 1, 0});
        // Fill to full under continuous PIPE traffic; fifth push refused
        tbl.push_back(vec_t'{1, 1, 32'hA1, 1, 10, 32'hB0,       1, 1, 32'hA1, 1, 32'h400, 1, 0});
        tbl.push_back(vec_t'{1, 2, 32'hA2, 1, 11, 32'hB1,       1, 2, 32'hA2, 2, 32'hC00, 1, 0});
        tbl.push_back(vec_t'{1, 3, 32'hA3, 1, 12, 32'hB2,       1, 3, 32'hA3, 3, 32'h1C00, 1, 0});
        tbl.push_back(vec_t'{1, 4, 32'hA4, 1, 13, 32'hB3,       1, 4, 32'hA4, 4, 32'h3C00, 0, 0});
        tbl.push_back(vec_t'{1, 5, 32'hA5, 1, 14, 32'hB4,       1, 5, 32'hA5, 4, 32'h3C00, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0,                  1, 10, 32'hB0, 3, 32'h3800, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0,                  1, 11, 32'hB1, 2, 32'h3000, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0,                  1, 12, 32'hB2, 1, 32'h2000, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0,                  1, 13, 32'hB3, 0, 32'h0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0,                  0, 13, 32'hB3, 0, 32'h0, 1, 0});
        // Push+pop at count 2 across a pointer wrap, six pushes in order
        tbl.push_back(vec_t'{1, 6, 32'hD0, 1, 20, 32'hC0,       1, 6, 32'hD0, 1, 32'h0010_0000, 1, 0});
        tbl.push_back(vec_t'{1, 7, 32'hD1, 1, 21, 32'hC1,       1, 7, 32'hD1, 2, 32'h0030_0000, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 22, 32'hC2,            1, 20, 32'hC0, 2, 32'h0060_0000, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 23, 32'hC3,            1, 21, 32'hC1, 2, 32'h00C0_0000, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 24, 32'hC4,            1, 22, 32'hC2, 2, 32'h0180_0000, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 25, 32'hC5,            1, 23, 32'hC3, 2, 32'h0300_0000, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0,                  1, 24, 32'hC4, 1, 32'h0200_0000, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0,                  1, 25, 32'hC5, 0, 32'h0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0,                  0, 25, 32'hC5, 0, 32'h0, 1, 0});

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-burst with three entries queued
        drive(1, 1, 32'h77, 1, 3, 32'h30);
        @(negedge clk);
        drive(1, 1, 32'h78, 1, 4, 32'h31);
        @(negedge clk);
        drive(1, 1, 32'h79, 1, 5, 32'h32);
        @(negedge clk);
        chk("pre_rst.fifo_count", 32'(fifo_count), 32'd3);
        chk("pre_rst.pend_mask",  pend_mask,       32'h38);
        chk("pre_rst.wr_en",      32'(wr_en),      32'd1);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.rd",         32'(rd),         32'd0);
        chk("rst.wr_en",      32'(wr_en),      32'd0);
        chk("rst.rd_value",   rd_value,        32'd0);
        chk("rst.fifo_count", 32'(fifo_count), 32'd0);
        chk("rst.pend_mask",  pend_mask,       32'd0);
        chk("rst.pipe_stall", 32'(pipe_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.mc_ready",   32'(mc_ready),   32'd1);
        chk("rel.fifo_count", 32'(fifo_count), 32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].pv, tbl[i].prd, tbl[i].pd, tbl[i].mv, tbl[i].mrd, tbl[i].md);
            @(negedge clk);
            chk_port($sformatf("vec%0d", i), tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_val,
                     tbl[i].e_cnt, tbl[i].e_pend, tbl[i].e_rdy, tbl[i].e_stall);
        end

        // Starvation: one queued entry against back-to-back PIPE writes
        drive(1, 1, 32'd100, 1, 9, 32'h55);
        @(negedge clk);
        chk_port("starve0", 1, 1, 32'd100, 1, 32'h200, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            drive(1, 2, 32'(200 + k), 0, 0, 0);
            @(negedge clk);
            chk_port($sformatf("starve%0d", k), 1, 2, 32'(200 + k), 1, 32'h200, 1, (k == 8));
        end
        drive(1, 2, 32'd209, 0, 0, 0);
        @(negedge clk);
        chk_port("starve_grant", 1, 9, 32'h55, 0, 32'h0, 1, 0);
        @(negedge clk);
        chk_port("starve_held", 1, 2, 32'd209, 0, 32'h0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_port("starve_idle", 0, 2, 32'd209, 0, 32'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
